regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-read-port register file, the successor to the current 2R/1W 32x32 file. Adds N read ports, byte-enabled writes, a hardware clear sequencer after reset, and a per-register pending-write scoreboard for pipeline hazard detection. Sits between decode (read/reserve) and writeback (write) in the core datapath.

Parameters:
XLEN, 32, data width in bits; multiple of 8
NREGS, 32, number of registers; power of 2, >= 2
NRD, 2, number of read ports
ZERO_REG0, 1, 1 = register 0 hardwired to zero: writes ignored, never pending

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ready  out  1  high once the clear sweep completes
wr_en  in  1  write strobe (writeback)
wr_addr  in  $clog2(NREGS)  write register index
wr_be  in  XLEN/8  byte enables for the write
wr_data  in  XLEN  write data
rsv_en  in  1  reserve strobe: mark register pending (issue)
rsv_addr  in  $clog2(NREGS)  register to reserve
rd_addr  in  NRD*$clog2(NREGS)  packed read addresses, port i at slice i
rd_data  out  NRD*XLEN  packed read data, combinational
rd_pend  out  NRD  pending bit of each read port's register

Behaviour:
- Reset: on rst_n low, immediately and asynchronously: state=CLEAR, clr_idx=0, ready=0, all pending bits=0. rd_data and rd_pend read 0 while in CLEAR.
- FSM: CLEAR -> READY. In CLEAR, after rst_n release, one register per cycle is written 0, idx 0..NREGS-1; READY entered on the cycle after idx NREGS-1 is cleared, so ready rises exactly NREGS cycles after the first rising edge with rst_n high. READY -> CLEAR only via reset. Reset mid-sweep restarts at idx 0.
- In CLEAR: wr_en and rsv_en ignored.
- Write (READY): on edge with wr_en=1, each byte b with wr_be[b]=1 takes wr_data[8b+7:8b]; other bytes unchanged. wr_be=0 writes nothing but still clears the pending bit. If ZERO_REG0 and wr_addr=0: no update.
- Read: rd_data slice i = reg[rd_addr_i], zero-latency combinational; reg 0 reads 0 when ZERO_REG0. Without bypass, a same-cycle write is visible the next cycle.
- Scoreboard: rsv_en sets pend[rsv_addr]; wr_en clears pend[wr_addr]. Same address, same cycle: reserve wins (pend=1). Different addresses: both apply. rsv_en on reg 0 with ZERO_REG0 ignored. Reserving an already-pending register: stays 1, no error.
- rd_pend i = pend[rd_addr_i], combinational from flops.
- Out-of-range addresses impossible (NREGS power of 2).

Optional Feature:
Macro REGFILE_MP_BYPASS_EN.
- Defined: write-through forwarding. If wr_en=1, state READY, and rd_addr_i==wr_addr (excluding reg 0 when ZERO_REG0), rd_data slice i returns the merged value (wr_data in enabled bytes, stored value elsewhere) in the same cycle; rd_pend i reads 0 that cycle unless rsv_en targets the same address.
- Undefined: no forwarding; reads return array contents, rd_pend reflects flops only.

Decomposition:
- Shared package regfile_pkg: state enum (CLEAR, READY), function for address width, default XLEN/NREGS constants.
- One sub-module: regfile_scoreboard (pending bits, reserve/clear priority, NRD lookup ports). Array, clear sequencer and bypass stay in top.

Test Plan:
- Reset/clear: NREGS=32, release rst_n -> ready=0 for 32 cycles, 1 on edge 32; all 32 registers read 0; write during CLEAR dropped.
- Byte-enable: reg5=0x11223344, write 0xAABBCCDD be=4'b0101 -> reads 0x11BB33DD next cycle.
- Reg 0: ZERO_REG0=1, write 0xFFFFFFFF to 0 and reserve 0 -> rd_data=0, rd_pend=0.
- Scoreboard: reserve r7 -> rd_pend=1 next cycle; same cycle write r7 + reserve r7 -> stays 1; write r7 only -> 0.
- Bypass: with macro, write r3=0xDEADBEEF be=all and read r3 same cycle -> 0xDEADBEEF that cycle; without macro -> old value, new one next cycle.
- Reset mid-sweep: assert rst_n at idx 10 -> ready=0; after release the full 32-cycle sweep reruns and pend stays cleared.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    // Register index width; at least one bit so a 1-entry corner still elaborates.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue (reserve),
// cleared at writeback. Reserve wins when both hit the same register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS     = NREGS_DEF,
    parameter  int NRD       = NRD_DEF,
    parameter  int ZERO_REG0 = 1,
    localparam int AW        = addr_w(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic                    rsv_en,
    input  logic [AW-1:0]           rsv_addr,
    input  logic [NRD-1:0][AW-1:0]  rd_addr,
    output logic [NRD-1:0]          rd_pend
);

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic             rsv_ok;

    // Register 0 can never become pending when it is hardwired.
    assign rsv_ok = rsv_en && !((ZERO_REG0 != 0) && (rsv_addr == '0));

    // Next pending vector: clear first so a same-address reserve overrides it.
    always_comb begin
        pend_nxt = pend;
        if (en) begin
            if (wr_en)
                pend_nxt[wr_addr] = 1'b0;
            if (rsv_ok)
                pend_nxt[rsv_addr] = 1'b1;
        end
    end

    // Pending flops, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pend <= '0;
        else
            pend <= pend_nxt;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_lookup
        assign rd_pend[i] = en & pend[rd_addr[i]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled writes, post-reset clear
// sweep and pending-write scoreboard.
// Optional feature: define REGFILE_MP_BYPASS_EN for same-cycle write forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN      = XLEN_DEF,
    parameter  int NREGS     = NREGS_DEF,
    parameter  int NRD       = NRD_DEF,
    parameter  int ZERO_REG0 = 1,
    localparam int AW        = addr_w(NREGS),
    localparam int NB        = XLEN / 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [NB-1:0]       wr_be,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_pend
);

    rf_state_e                   state;
    rf_state_e                   state_nxt;
    logic [AW-1:0]               clr_idx;
    logic [NREGS-1:0][XLEN-1:0]  mem;
    logic [NRD-1:0][AW-1:0]      ra;
    logic [NRD-1:0][XLEN-1:0]    rdat;
    logic [NRD-1:0]              sb_pend;
    logic [NRD-1:0]              pend_o;
    logic [XLEN-1:0]             wmask;
    logic [XLEN-1:0]             merged;
    logic                        wr_ok;

    assign ra      = rd_addr;
    assign rd_data = rdat;
    assign rd_pend = pend_o;
    assign ready   = (state == READY);

    // Writes land only after the sweep, and never on a hardwired register 0.
    assign wr_ok = ready && wr_en && !((ZERO_REG0 != 0) && (wr_addr == '0));

    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign wmask[8*b +: 8] = {8{wr_be[b]}};
    end

    // Byte merge shared by the array write and the forwarding path.
    assign merged = (mem[wr_addr] & ~wmask) | (wr_data & wmask);

    // State register and sweep index; reset restarts the sweep from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                clr_idx <= clr_idx + AW'(1);
        end
    end

    // Leave CLEAR on the edge that zeroes the last register.
    always_comb begin
        state_nxt = state;
        if ((state == CLEAR) && (clr_idx == AW'(NREGS - 1)))
            state_nxt = READY;
    end

    // Storage: sweep zeroes one entry per cycle, then normal byte writes.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_idx] <= '0;
        else if (wr_ok)
            mem[wr_addr] <= merged;
    end

    regfile_scoreboard #(
        .NREGS     (NREGS),
        .NRD       (NRD),
        .ZERO_REG0 (ZERO_REG0)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (ra),
        .rd_pend  (sb_pend)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [XLEN-1:0] d;
        logic            p;

        // Per-port read: array lookup, optional forward, then zero masking.
        always_comb begin
            d = mem[ra[i]];
            p = sb_pend[i];
`ifdef REGFILE_MP_BYPASS_EN
            if (wr_ok && (ra[i] == wr_addr)) begin
                d = merged;
                p = rsv_en && (rsv_addr == wr_addr);
            end
`endif
            if (!ready || ((ZERO_REG0 != 0) && (ra[i] == '0)))
                d = '0;
        end

        assign rdat[i]   = d;
        assign pend_o[i] = p;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: reset sweep, table vectors, bypass and
// mid-sweep reset sequences, then randomized traffic against a reference model.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
    localparam int NB    = 4;

    logic                clk;
    logic                rst_n;
    logic                ready;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [NB-1:0]       wr_be;
    logic [XLEN-1:0]     wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_pend;

    int checks   = 0;
    int failures = 0;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG0(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_pend  (rd_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [NB-1:0] be;
        logic [31:0]   wd;
        logic          rs;
        logic [AW-1:0] ra;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [31:0]   e0;
        logic [31:0]   e1;
        logic          p0;
        logic          p1;
    } vec_t;

    vec_t tbl[9];

    // Reference model state.
    logic [31:0] mem_m[NREGS];
    logic        pend_m[NREGS];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    function automatic logic [31:0] port_d(input int i);
        return rd_data[i*XLEN +: XLEN];
    endfunction

    // Byte merge computed from the write rule, one byte at a time.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [NB-1:0] be);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < NB; b++)
            if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
        return v;
    endfunction

    task automatic sweep_check(input string nm);
        for (int k = 1; k <= NREGS; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk(nm, {31'd0, ready}, (k == NREGS) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'd5, 4'hF, 32'h11223344, 1'b0, 5'd0, 5'd5, 5'd0, 32'h11223344, 32'h0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 5'd5, 4'b0101, 32'hAABBCCDD, 1'b0, 5'd0, 5'd5, 5'd0, 32'h11BB33DD, 32'h0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd5, 32'h0, 32'h11BB33DD, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd5, 32'h0, 32'h11BB33DD, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 5'd7, 4'hF, 32'h12345678, 1'b1, 5'd7, 5'd7, 5'd5, 32'h12345678, 32'h11BB33DD, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 5'd7, 4'h0, 32'hCAFEF00D, 1'b0, 5'd0, 5'd7, 5'd5, 32'h12345678, 32'h11BB33DD, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 5'd5, 4'b1000, 32'h0, 1'b1, 5'd9, 5'd9, 5'd5, 32'h0, 32'h00BB33DD, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd5, 32'h0, 32'h00BB33DD, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 5'd9, 4'b0011, 32'h0000BEEF, 1'b0, 5'd0, 5'd9, 5'd5, 32'h0000BEEF, 32'h00BB33DD, 1'b0, 1'b0};

        rst_n = 1'b1;
        idle();
        wr_addr = '0; wr_be = '0; wr_data = '0; rsv_addr = '0;
        set_rd(5'd5, 5'd9);
        #1 rst_n = 1'b0;

        // Reset state, then sweep with writes/reserves that must be dropped.
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_data", port_d(0), 32'd0);
        chk("rst_pend", {30'd0, rd_pend}, 32'd0);
        wr_en = 1'b1; wr_addr = 5'd5; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        rst_n = 1'b1;
        sweep_check("sweep_ready");
        idle();

        for (int r = 0; r < NREGS; r++) begin
            set_rd(AW'(r), AW'(NREGS - 1 - r));
            #1;
            chk("clr_d0", port_d(0), 32'd0);
            chk("clr_d1", port_d(1), 32'd0);
            chk("clr_pend", {30'd0, rd_pend}, 32'd0);
        end

        // Table-driven vectors: apply for one edge, check after it.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_be = tbl[i].be; wr_data = tbl[i].wd;
            rsv_en = tbl[i].rs; rsv_addr = tbl[i].ra;
            set_rd(tbl[i].a0, tbl[i].a1);
            @(posedge clk);
            #1 idle();
            @(negedge clk);
            chk($sformatf("vec%0d_d0", i), port_d(0), tbl[i].e0);
            chk($sformatf("vec%0d_d1", i), port_d(1), tbl[i].e1);
            chk($sformatf("vec%0d_p0", i), {31'd0, rd_pend[0]}, {31'd0, tbl[i].p0});
            chk($sformatf("vec%0d_p1", i), {31'd0, rd_pend[1]}, {31'd0, tbl[i].p1});
        end

        // Same-cycle write and read of r3.
        rsv_en = 1'b1; rsv_addr = 5'd3;
        set_rd(5'd3, 5'd5);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        chk("byp_pre_pend", {31'd0, rd_pend[0]}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        chk("byp_same_d", port_d(0), 32'hDEADBEEF);
        chk("byp_same_p", {31'd0, rd_pend[0]}, 32'd0);
`else
        chk("byp_same_d", port_d(0), 32'd0);
        chk("byp_same_p", {31'd0, rd_pend[0]}, 32'd1);
`endif
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        chk("byp_next_d", port_d(0), 32'hDEADBEEF);
        chk("byp_next_p", {31'd0, rd_pend[0]}, 32'd0);

        // Reset during a sweep: pending bits cleared, sweep reruns in full.
        rsv_en = 1'b1; rsv_addr = 5'd12;
        set_rd(5'd12, 5'd5);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        chk("mid_pre_pend", {31'd0, rd_pend[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, ready}, 32'd0);
        chk("mid_rst_pend", {30'd0, rd_pend}, 32'd0);
        chk("mid_rst_data", port_d(1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mid_sweep_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_sweep_rst", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check("resweep_ready");
        set_rd(5'd12, 5'd5);
        #1;
        chk("resweep_pend12", {31'd0, rd_pend[0]}, 32'd0);
        chk("resweep_r5", port_d(1), 32'd0);
        set_rd(5'd3, 5'd9);
        #1;
        chk("resweep_r3", port_d(0), 32'd0);
        chk("resweep_r9", port_d(1), 32'd0);

        // Randomized traffic against the model; the file is all zero here.
        for (int r = 0; r < NREGS; r++) begin
            mem_m[r]  = '0;
            pend_m[r] = 1'b0;
        end
        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] a[NRD];
            logic [31:0]   exp_d;
            logic          exp_p;
            @(negedge clk);
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = AW'($urandom_range(0, NREGS - 1));
            wr_be    = NB'($urandom);
            wr_data  = $urandom;
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
            for (int i = 0; i < NRD; i++)
                a[i] = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
            set_rd(a[0], a[1]);
            #2;
            chk("rnd_ready", {31'd0, ready}, 32'd1);
            for (int i = 0; i < NRD; i++) begin
                exp_d = (a[i] == 0) ? 32'd0 : mem_m[a[i]];
                exp_p = pend_m[a[i]];
`ifdef REGFILE_MP_BYPASS_EN
                if (wr_en && a[i] == wr_addr && a[i] != 0) begin
                    exp_d = merge(mem_m[a[i]], wr_data, wr_be);
                    exp_p = rsv_en && (rsv_addr == a[i]);
                end
`endif
                chk($sformatf("rnd%0d_d%0d", n, i), port_d(i), exp_d);
                chk($sformatf("rnd%0d_p%0d", n, i), {31'd0, rd_pend[i]}, {31'd0, exp_p});
            end
            @(posedge clk);
            if (wr_en && wr_addr != 0)
                mem_m[wr_addr] = merge(mem_m[wr_addr], wr_data, wr_be);
            if (wr_en)
                pend_m[wr_addr] = 1'b0;
            if (rsv_en && rsv_addr != 0)
                pend_m[rsv_addr] = 1'b1;
        end

        @(negedge clk);
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
